// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The state enum always contains PARITY so that state encodings are the same with or without UART_RX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    // Tick counter value at the middle of the start bit and of every later bit.
    function automatic int unsigned mid_start_tick(input int unsigned os);
        return os / 2 - 1;
    endfunction

    function automatic int unsigned mid_bit_tick(input int unsigned os);
        return os - 1;
    endfunction

    localparam int unsigned UART_MID_START_TICK = mid_start_tick(UART_OVERSAMPLE);
    localparam int unsigned UART_MID_BIT_TICK   = mid_bit_tick(UART_OVERSAMPLE);

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchronizer for the asynchronous rx line.
// All stages reset to 1, which is the idle level of the line.
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversample strobe; delivers one byte per frame as a one-cycle pulse.
// Defining UART_RX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rxclk_en_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] MID_START_C = CNT_W'(mid_start_tick(OVERSAMPLE));
    localparam logic [CNT_W-1:0] MID_BIT_C   = CNT_W'(mid_bit_tick(OVERSAMPLE));
    localparam logic [BIT_W-1:0] LAST_BIT_C  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .d_i    (rx_i),
        .q_o    (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        if (rxclk_en_i) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == MID_START_C) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == MID_BIT_C) begin
                        cnt_d     = '0;
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == LAST_BIT_C) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == MID_BIT_C) begin
                        cnt_d     = '0;
                        par_bit_d = rx_s;
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == MID_BIT_C) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = (^shift_q) ^ par_bit_q;
`endif
                            state_d      = IDLE;
                        end else begin
                            // A low stop bit reports a framing error only; parity is not judged.
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: strobe every 4 clocks, so one bit lasts 64 clocks.
// Build with UART_RX_PARITY_EN defined to exercise the parity frames as well.
module tb_uart_rx;

    logic       clk_i;
    logic       rst_n_i;
    logic       rxclk_en_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       busy_o;

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rxclk_en_i  (rxclk_en_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .busy_o      (busy_o)
    );

    int vectors;
    int miscompares;

    int         valid_cnt;
    int         ferr_cnt;
    int         perr_cnt;
    int         coinc_cnt;
    int         wide_cnt;
    int         cyc;
    logic       busy_seen;
    logic [7:0] vdata[4];
    int         vcyc[4];
    logic       prev_v, prev_f, prev_p;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        rxclk_en_i = 1'b0;
        forever begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk_i);
                rxclk_en_i = (k == 3);
            end
        end
    end

    // Pulse monitor, sampled on the inactive edge.
    initial begin
        cyc = 0;
        wide_cnt = 0;
        prev_v = 1'b0;
        prev_f = 1'b0;
        prev_p = 1'b0;
        forever begin
            @(negedge clk_i);
            if (data_valid_o) begin
                if (valid_cnt < 4) begin
                    vdata[valid_cnt] = data_o;
                    vcyc[valid_cnt]  = cyc;
                end
                valid_cnt = valid_cnt + 1;
                if (parity_err_o) coinc_cnt = coinc_cnt + 1;
            end
            if (frame_err_o) ferr_cnt = ferr_cnt + 1;
            if (parity_err_o) perr_cnt = perr_cnt + 1;
            if ((data_valid_o && prev_v) || (frame_err_o && prev_f) || (parity_err_o && prev_p))
                wide_cnt = wide_cnt + 1;
            if (busy_o) busy_seen = 1'b1;
            prev_v = data_valid_o;
            prev_f = frame_err_o;
            prev_p = parity_err_o;
            cyc = cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (got === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        ferr_cnt  = 0;
        perr_cnt  = 0;
        coinc_cnt = 0;
        busy_seen = 1'b0;
    endtask

    task automatic bit_period(input logic v);
        rx_i = v;
        repeat (64) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic use_par, input logic par_v);
        logic [7:0] tmp;
        tmp = b;
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(tmp[i]);
        if (use_par) bit_period(par_v);
        bit_period(stop_v);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_counts();
        rst_n_i = 1'b0;
        rx_i    = 1'b1;
        repeat (10) @(negedge clk_i);

        check("reset_data",   {24'd0, data_o}, 32'h00);
        check("reset_valid",  {31'd0, data_valid_o}, 32'd0);
        check("reset_ferr",   {31'd0, frame_err_o}, 32'd0);
        check("reset_perr",   {31'd0, parity_err_o}, 32'd0);
        check("reset_busy",   {31'd0, busy_o}, 32'd0);

        rst_n_i = 1'b1;
        repeat (128) @(negedge clk_i);

        // Plain 0x55 frame.
        clear_counts();
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        repeat (64) @(negedge clk_i);
        check("f55_valid_cnt", valid_cnt, 1);
        check("f55_ferr_cnt",  ferr_cnt, 0);
        check("f55_data",      {24'd0, data_o}, 32'h55);
        check("f55_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("f55_busy_end",  {31'd0, busy_o}, 32'd0);

        // Start-bit glitch of 3 ticks.
        clear_counts();
        rx_i = 1'b0;
        repeat (12) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (128) @(negedge clk_i);
        check("glitch_valid", valid_cnt, 0);
        check("glitch_ferr",  ferr_cnt, 0);
        check("glitch_data",  {24'd0, data_o}, 32'h55);
        check("glitch_busy",  {31'd0, busy_o}, 32'd0);

        // 0xA3 with a low stop bit followed by a 40-tick break.
        clear_counts();
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (160) @(negedge clk_i);
        check("break_busy_low", {31'd0, busy_o}, 32'd1);
        rx_i = 1'b1;
        repeat (128) @(negedge clk_i);
        check("break_ferr",  ferr_cnt, 1);
        check("break_valid", valid_cnt, 0);
        check("break_data",  {24'd0, data_o}, 32'h55);
        check("break_busy",  {31'd0, busy_o}, 32'd0);

        clear_counts();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        repeat (64) @(negedge clk_i);
        check("f3c_valid", valid_cnt, 1);
        check("f3c_data",  {24'd0, data_o}, 32'h3C);
        check("f3c_ferr",  ferr_cnt, 0);

        // Back-to-back frames with no idle gap.
        clear_counts();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        repeat (64) @(negedge clk_i);
        check("b2b_valid_cnt", valid_cnt, 2);
        check("b2b_data0",     {24'd0, vdata[0]}, 32'hA5);
        check("b2b_data1",     {24'd0, vdata[1]}, 32'h0F);
        check("b2b_spacing",   vcyc[1] - vcyc[0], 640);
        check("b2b_ferr",      ferr_cnt, 0);

        // Reset in the middle of data bit 4 of 0xFF.
        clear_counts();
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(1'b1);
        rx_i = 1'b1;
        repeat (32) @(negedge clk_i);
        rst_n_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        check("rst_mid_data", {24'd0, data_o}, 32'h00);
        rst_n_i = 1'b1;
        repeat (384) @(negedge clk_i);
        check("rst_abort_valid", valid_cnt, 0);
        check("rst_abort_ferr",  ferr_cnt, 0);
        clear_counts();
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        repeat (64) @(negedge clk_i);
        check("f12_valid", valid_cnt, 1);
        check("f12_data",  {24'd0, data_o}, 32'h12);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: even parity expects a 1.
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (64) @(negedge clk_i);
        check("par_bad_valid", valid_cnt, 1);
        check("par_bad_perr",  perr_cnt, 1);
        check("par_bad_coinc", coinc_cnt, 1);
        check("par_bad_data",  {24'd0, data_o}, 32'h07);

        clear_counts();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (64) @(negedge clk_i);
        check("par_ok_valid", valid_cnt, 1);
        check("par_ok_perr",  perr_cnt, 0);
        check("par_ok_data",  {24'd0, data_o}, 32'h07);

        clear_counts();
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        rx_i = 1'b1;
        repeat (128) @(negedge clk_i);
        check("par_ferr_ferr",  ferr_cnt, 1);
        check("par_ferr_perr",  perr_cnt, 0);
        check("par_ferr_valid", valid_cnt, 0);
`else
        check("noparity_perr", perr_cnt, 0);
`endif

        check("pulse_width", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that sits directly downstream of the baud-rate generator.
- Uses the 16x oversample strobe from that generator to detect the start bit, sample each bit at mid-bit, check the stop bit and deliver one received byte per frame.
- Output goes to the UART register/FIFO stage via a single-cycle valid pulse; there is no back-pressure.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- OVERSAMPLE, 16, rxclk_en_i ticks per bit period.
- SYNC_STAGES, 2, flip-flop stages in the rx_i synchronizer (min 2).

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  reset, asynchronous, active-low
- rxclk_en_i  input  1  one-clk_i-wide 16x oversample strobe
- rx_i  input  1  asynchronous serial line, idle high
- data_o  output  DATA_BITS  last good received byte
- data_valid_o  output  1  one-cycle pulse: data_o updated
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- parity_err_o  output  1  one-cycle pulse: parity mismatch (tied 0 without the macro)
- busy_o  output  1  high while a frame is in progress

Behaviour:
- Reset values: synchronizer flops = 1; state = IDLE; tick counter = 0; bit index = 0; shift register = 0; data_o = 0; all pulse outputs = 0; busy_o = 0.
- rx_i passes through SYNC_STAGES flops giving rx_s. All decisions use rx_s.
- Counter width is $clog2(OVERSAMPLE). The counter advances only on rxclk_en_i and clears on every state transition.
- IDLE:
  - On a tick with rx_s == 0: go to START, counter = 0.
- START:
  - On each tick, counter++.
  - On the tick where counter == OVERSAMPLE/2-1 (7), sample rx_s.
  - rx_s == 1: glitch; return to IDLE with no output.
  - rx_s == 0: go to DATA, bit index = 0.
- DATA:
  - On the tick where counter == OVERSAMPLE-1 (15, i.e. mid-bit), shift rx_s into the MSB of the shift register (LSB-first reception) and increment bit index.
  - After DATA_BITS samples: go to STOP, or PARITY when the macro is enabled.
- STOP: on the mid-bit tick, sample rx_s.
  - rx_s == 1: data_o <= shift register; data_valid_o = 1 for exactly one clk_i; go to IDLE.
  - rx_s == 0: frame_err_o = 1 for one clk_i; data_o is unchanged; go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until a tick with rx_s == 1, then go to IDLE. This ensures a break condition produces exactly one error.
- Latency: pulses assert on the clk_i cycle after the mid-stop-bit tick. No pulse ever lasts longer than one cycle.
- busy_o = (state != IDLE).
- A new start bit may begin on the tick immediately after returning to IDLE, so back-to-back frames with one stop bit are supported.
- rxclk_en_i held low: the FSM freezes with no timeout.
- Asserting rst_n_i mid-frame immediately returns every register to its reset value; the partial byte is discarded and no pulse is issued.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Enabled:
  - Adds a PARITY state between DATA and STOP, sampled at mid-bit.
  - Even parity: the parity bit must equal the XOR of the data bits.
  - On a mismatch, parity_err_o pulses at the end of STOP, on the same cycle data_valid_o would pulse; data_o is still updated.
  - A framing error overrides: frame_err_o pulses only, with no parity_err_o or data_valid_o.
- Disabled:
  - No PARITY state exists; the frame is 8N1.
  - parity_err_o is a constant 0.

Decomposition:
- Package uart_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH;
  - the OVERSAMPLE default and the mid-start / mid-bit tick constants;
  - the data-width localparam.
- One sub-module, uart_sync: an SYNC_STAGES-deep synchronizer with reset value 1.

Test Plan:
- Bench drives rxclk_en_i every 4 clk_i, so one bit = 64 clk_i.
- Frame 0x55 (start, 1,0,1,0,1,0,1,0 LSB first, stop) -> data_o = 0x55, one data_valid_o pulse, frame_err_o = 0, busy_o low after the pulse.
- rx_i low for 3 ticks, then high -> FSM returns to IDLE at tick 7; no pulses; data_o keeps its previous value.
- Frame 0xA3 with stop bit = 0, line held low for 40 ticks -> exactly one frame_err_o pulse, data_o unchanged; next frame 0x3C -> data_o = 0x3C.
- Back-to-back 0xA5 and 0x0F with no idle gap -> two data_valid_o pulses 10 bit periods apart, with data values matching.
- rst_n_i asserted in the middle of data bit 4 of 0xFF, then released, then 0x12 sent -> no pulse from the aborted frame; data_o = 0x12.
- Macro on: 0x07 with parity bit 0 -> data_valid_o and parity_err_o pulse together, data_o = 0x07; with parity bit 1 -> no parity_err_o.
